// File: rtl/banco_registradores_pkg.sv
// Shared definitions for the MIPS integer register file: data/address widths,
// the clear-sequencer state encoding and the hard-wired zero register index.
package banco_registradores_pkg;

    localparam int LARGURA  = 32;   // data width in bits
    localparam int NUM_REGS = 32;   // architectural registers (power of two)
    localparam int END_W    = 5;    // log2(NUM_REGS)

    // Clear-sequencer states, kept as plain constants for older tools.
    localparam logic [0:0] LIMPANDO = 1'b0;
    localparam logic [0:0] PRONTO   = 1'b1;

    // Register 0 is hard-wired to zero in the MIPS ISA.
    localparam logic [END_W-1:0] REG_ZERO = '0;

    typedef logic [LARGURA-1:0] palavra_t;
    typedef logic [END_W-1:0]   endereco_t;

endpackage

// File: rtl/banco_registradores_sequenciador_limpeza.sv
// Post-reset clear sequencer: walks every register index once, one per
// cycle, so the RAM-style array (which has no bulk clear) starts at zero,
// then raises pronto and stays there until the next reset.
module sequenciador_limpeza
    import banco_registradores_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    output logic             limpa_en,
    output logic [END_W-1:0] limpa_idx,
    output logic             pronto
);

    logic [0:0]       estado;
    logic [END_W-1:0] contador;

    // State, index counter and ready flag; reset restarts the sweep at index 0.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            estado   <= LIMPANDO;
            contador <= '0;
            pronto   <= 1'b0;
        end else if (estado == LIMPANDO) begin
            contador <= contador + END_W'(1);
            if (contador == END_W'(NUM_REGS - 1)) begin
                estado <= PRONTO;
                pronto <= 1'b1;
            end
        end
    end

    // Clear request to the array; suppressed on reset edges so contents stay put.
    always_comb begin
        limpa_en  = (estado == LIMPANDO) && !reset;
        limpa_idx = contador;
    end

endmodule

// File: rtl/banco_registradores.sv
// MIPS integer register file: NUM_REGS x LARGURA, two combinational read
// ports, one synchronous write port. Contents are zeroed by an internal
// sequencer after reset; reads return zero until that finishes, and writes
// attempted before then are dropped and latched into EscritaPerdida.
// Optional build macro: BANCO_BYPASS_EN forwards same-cycle write data to
// the read ports (write-back in the first half-cycle).
module banco_registradores
    import banco_registradores_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               EscreveRegFlag,
    input  logic [END_W-1:0]   EscreveReg,
    input  logic [LARGURA-1:0] DadoEscrita,
    input  logic [END_W-1:0]   LeReg1,
    input  logic [END_W-1:0]   LeReg2,
    output logic [LARGURA-1:0] Dado1,
    output logic [LARGURA-1:0] Dado2,
    output logic               Pronto,
    output logic               EscritaPerdida
);

    logic [LARGURA-1:0] regs [NUM_REGS];
    logic               limpa_en;
    logic [END_W-1:0]   limpa_idx;
    logic               escrita_valida;

    sequenciador_limpeza u_seq (
        .clock     (clock),
        .reset     (reset),
        .limpa_en  (limpa_en),
        .limpa_idx (limpa_idx),
        .pronto    (Pronto)
    );

    assign escrita_valida = Pronto && EscreveRegFlag && (EscreveReg != REG_ZERO);

    // Array update: sequencer clear has priority, architectural writes only when ready.
    always_ff @(posedge clock) begin
        // NOTE: the array has no reset term on purpose; it maps onto RAM and is
        // zeroed one entry per cycle by the sequencer instead.
        if (!reset) begin
            if (limpa_en) begin
                regs[limpa_idx] <= '0;
            end else if (escrita_valida) begin
                regs[EscreveReg] <= DadoEscrita;
            end
        end
    end

    // Sticky dropped-write flag; writes aimed at r0 never count as dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            EscritaPerdida <= 1'b0;
        end else if (!Pronto && EscreveRegFlag && (EscreveReg != REG_ZERO)) begin
            EscritaPerdida <= 1'b1;
        end
    end

    // Read ports: zero while clearing or for r0, optional forward, else array.
    always_comb begin
        // NOTE: both outputs get a default first so no path leaves them
        // unassigned and infers a latch.
        Dado1 = '0;
        Dado2 = '0;
        if (Pronto) begin
            if (LeReg1 != REG_ZERO) begin
                Dado1 = regs[LeReg1];
`ifdef BANCO_BYPASS_EN
                if (escrita_valida && (EscreveReg == LeReg1)) begin
                    Dado1 = DadoEscrita;
                end
`endif
            end
            if (LeReg2 != REG_ZERO) begin
                Dado2 = regs[LeReg2];
`ifdef BANCO_BYPASS_EN
                if (escrita_valida && (EscreveReg == LeReg2)) begin
                    Dado2 = DadoEscrita;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_banco_registradores.sv
// Self-checking bench for banco_registradores: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the file.
module tb_banco_registradores;
    import banco_registradores_pkg::*;

    logic               clock = 1'b0;
    logic               reset;
    logic               EscreveRegFlag;
    logic [END_W-1:0]   EscreveReg;
    logic [LARGURA-1:0] DadoEscrita;
    logic [END_W-1:0]   LeReg1;
    logic [END_W-1:0]   LeReg2;
    logic [LARGURA-1:0] Dado1;
    logic [LARGURA-1:0] Dado2;
    logic               Pronto;
    logic               EscritaPerdida;

    int compared   = 0;
    int mismatched = 0;

    // Behavioural model: register values, how many entries have been
    // cleared since reset, and the dropped-write flag.
    logic [LARGURA-1:0] modelo [NUM_REGS];
    int                 limpos;
    bit                 perdida_m;

    banco_registradores dut (
        .clock          (clock),
        .reset          (reset),
        .EscreveRegFlag (EscreveRegFlag),
        .EscreveReg     (EscreveReg),
        .DadoEscrita    (DadoEscrita),
        .LeReg1         (LeReg1),
        .LeReg2         (LeReg2),
        .Dado1          (Dado1),
        .Dado2          (Dado2),
        .Pronto         (Pronto),
        .EscritaPerdida (EscritaPerdida)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "simulation did not finish");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [LARGURA-1:0] esperado(input logic [END_W-1:0] a);
        if (limpos < NUM_REGS || a == 0) return '0;
`ifdef BANCO_BYPASS_EN
        if (EscreveRegFlag && EscreveReg == a) return DadoEscrita;
`endif
        return modelo[a];
    endfunction

    // One rising edge: apply the architectural rules to the model using the
    // inputs present at that edge, then step just past the edge.
    task automatic tick();
        @(posedge clock);
        if (reset) begin
            limpos    = 0;
            perdida_m = 1'b0;
        end else if (limpos < NUM_REGS) begin
            modelo[limpos] = '0;
            if (EscreveRegFlag && EscreveReg != 0) perdida_m = 1'b1;
            limpos++;
        end else if (EscreveRegFlag && EscreveReg != 0) begin
            modelo[EscreveReg] = DadoEscrita;
        end
        #1;
    endtask

    task automatic check_all(input string tag);
        #1;
        check({tag, "/pronto"},  {31'd0, Pronto},         {31'd0, limpos == NUM_REGS});
        check({tag, "/perdida"}, {31'd0, EscritaPerdida}, {31'd0, perdida_m});
        check({tag, "/dado1"},   Dado1, esperado(LeReg1));
        check({tag, "/dado2"},   Dado2, esperado(LeReg2));
    endtask

    initial begin
        for (int i = 0; i < NUM_REGS; i++) modelo[i] = '0;
        limpos         = 0;
        perdida_m      = 1'b0;
        reset          = 1'b1;
        EscreveRegFlag = 1'b0;
        EscreveReg     = '0;
        DadoEscrita    = '0;
        LeReg1         = 5'd7;
        LeReg2         = 5'd13;

        // 1: two reset cycles, then count edges to Pronto and read everything.
        tick();
        tick();
        check_all("reset");
        reset = 1'b0;
        for (int i = 1; i <= NUM_REGS; i++) begin
            LeReg1 = 5'($urandom);
            LeReg2 = 5'($urandom);
            tick();
            #1;
            check("clr_pronto", {31'd0, Pronto}, (i == NUM_REGS) ? 32'd1 : 32'd0);
            check("clr_dado1", Dado1, 32'd0);
        end
        for (int a = 0; a < NUM_REGS; a++) begin
            LeReg1 = 5'(a);
            LeReg2 = 5'(NUM_REGS - 1 - a);
            check_all("zero_all");
        end

        // 2: write r8, read it back on both ports.
        EscreveRegFlag = 1'b1;
        EscreveReg     = 5'd8;
        DadoEscrita    = 32'hDEADBEEF;
        tick();
        EscreveRegFlag = 1'b0;
        LeReg1         = 5'd8;
        LeReg2         = 5'd8;
        #1;
        check("r8_port1", Dado1, 32'hDEADBEEF);
        check("r8_port2", Dado2, 32'hDEADBEEF);

        // 3: write to r0 is ignored and not flagged.
        EscreveRegFlag = 1'b1;
        EscreveReg     = 5'd0;
        DadoEscrita    = 32'h12345678;
        tick();
        EscreveRegFlag = 1'b0;
        LeReg1         = 5'd0;
        #1;
        check("r0_read", Dado1, 32'd0);
        check("r0_perdida", {31'd0, EscritaPerdida}, 32'd0);

        // 4: write during clearing (edge 10) is dropped and flagged.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 1; i <= NUM_REGS; i++) begin
            EscreveRegFlag = (i == 10);
            EscreveReg     = 5'd5;
            DadoEscrita    = 32'hA5A5A5A5;
            tick();
            if (i == 10) begin
                #1;
                check("drop_flag", {31'd0, EscritaPerdida}, 32'd1);
            end
        end
        EscreveRegFlag = 1'b0;
        LeReg1         = 5'd5;
        #1;
        check("drop_r5", Dado1, 32'd0);
        check("drop_pronto", {31'd0, Pronto}, 32'd1);
        check("drop_sticky", {31'd0, EscritaPerdida}, 32'd1);
        tick();
        check_all("drop_after");

        // 5: reset asserted mid-clear restarts the full sweep.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            if (i == 20) begin
                EscreveRegFlag = 1'b1;
                EscreveReg     = 5'd3;
                DadoEscrita    = 32'h11;
                reset          = 1'b1;
            end
            tick();
        end
        reset          = 1'b0;
        EscreveRegFlag = 1'b0;
        for (int i = 1; i <= NUM_REGS; i++) begin
            tick();
            if (i >= NUM_REGS - 1) begin
                #1;
                check("restart_pronto", {31'd0, Pronto}, (i == NUM_REGS) ? 32'd1 : 32'd0);
            end
        end
        for (int a = 0; a < NUM_REGS; a++) begin
            LeReg1 = 5'(a);
            LeReg2 = 5'(a);
            check_all("restart_zero");
        end

        // 6: same-cycle read of the register being written.
        EscreveRegFlag = 1'b1;
        EscreveReg     = 5'd9;
        DadoEscrita    = 32'h1;
        tick();
        DadoEscrita    = 32'h2;
        LeReg1         = 5'd9;
        #1;
`ifdef BANCO_BYPASS_EN
        check("same_cycle", Dado1, 32'h2);
`else
        check("same_cycle", Dado1, 32'h1);
`endif
        tick();
        EscreveRegFlag = 1'b0;
        #1;
        check("next_cycle", Dado1, 32'h2);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            reset          = ($urandom_range(0, 199) == 0);
            EscreveRegFlag = 1'($urandom);
            EscreveReg     = 5'($urandom);
            DadoEscrita    = $urandom;
            LeReg1         = ($urandom_range(0, 3) == 0) ? EscreveReg : 5'($urandom);
            LeReg2         = ($urandom_range(0, 3) == 0) ? EscreveReg : 5'($urandom);
            check_all("rnd");
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
